jk_latch_bist: RTL and testbench
================================

Name: jk_latch_bist

Overview:
- Synthesizable stimulus-and-check engine for the team's JK latch/flip-flop cells. It drives j/k/enable into a device under test (DUT) and samples q/q_bar.
- It compares the samples against an internal reference model and reports pass/fail with an error count.
- Sits beside the DUT in hardware, so the cell can be exercised on silicon/FPGA without a simulation bench.

Parameters:
- SETTLE_CYCLES, 2, cycles held after each vector before sampling; legal range 1..15.
- TEST_TOGGLE, 1, 1 = include j=k=1 toggle vectors; 0 = substitute non-toggle vectors.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a test run; sampled in IDLE or DONE only.
- dut_j  output  1  j drive to DUT.
- dut_k  output  1  k drive to DUT.
- dut_enable  output  1  enable drive to DUT; only ever a single-cycle pulse.
- dut_q  input  1  DUT q.
- dut_q_bar  input  1  DUT q_bar.
- busy  output  1  run in progress.
- done  output  1  run complete; held until next start or rst.
- pass  output  1  valid when done; 1 = zero errors.
- err_count  output  4  failing vectors this run, 0..8.
- fail_index  output  3  index of first failing vector; 0 if none.

Behaviour:
- Reset (rst=1 at clk edge, any state, including mid-run):
  - state=IDLE.
  - dut_j=dut_k=dut_enable=0.
  - busy=done=pass=0, err_count=0, fail_index=0.
  - Internal vector index and settle counter = 0.
- Vector table, fixed (j,k,en -> expected q):
  - 0: 0,1,1->0
  - 1: 0,0,1->0
  - 2: 1,0,1->1
  - 3: 0,0,0->1
  - 4: 0,1,0->1
  - 5: 1,1,1->0
  - 6: 1,1,1->1
  - 7: 0,1,1->0
  - TEST_TOGGLE=0 replaces vector 5 with 1,0,1->1 and vector 6 with 0,0,1->1.
- FSM states IDLE, APPLY, SETTLE, CHECK, DONE:
  - IDLE/DONE + start=1 -> APPLY. On that edge: index=0, err_count=0, fail_index=0, done=0, pass=0, busy=1.
  - APPLY (1 cycle): dut_j/dut_k = vector values; dut_enable = vector en. -> SETTLE.
  - SETTLE (SETTLE_CYCLES cycles): dut_enable=0; dut_j/dut_k held. -> CHECK when the counter reaches SETTLE_CYCLES-1.
  - CHECK (1 cycle): mismatch if dut_q != expected or dut_q_bar != ~dut_q.
    - On mismatch: err_count += 1. If this is the first mismatch, fail_index = index.
    - If index==7 -> DONE, else index+1 -> APPLY.
  - DONE: busy=0, done=1, pass=(err_count==0); dut_j=dut_k=dut_enable=0.
- Timing:
  - Per-vector time is SETTLE_CYCLES+2 cycles.
  - With start sampled at cycle 0, done rises at cycle 1+8*(SETTLE_CYCLES+2).
- start is ignored while busy=1 (APPLY/SETTLE/CHECK).
- start held high in DONE restarts immediately. The restart clears results on the same edge that leaves DONE.
- Vector 0 establishes a known q, so no DUT reset is required.
- err_count never exceeds 8; no wrap logic is needed, but the width must stay 4 bits.
- dut_q/dut_q_bar are sampled only in CHECK. X/glitches in other states are ignored.

Test Plan:
- Correct behavioural JK flop DUT (updates on enable pulse), SETTLE_CYCLES=2, start pulse at cycle 0 -> busy 1..32, done=1 at cycle 33, pass=1, err_count=0, fail_index=0.
- DUT q stuck at 0, q_bar=1 -> err_count=4 (vectors 2,3,4,6), fail_index=2, pass=0.
- DUT with q_bar tied to q (otherwise correct) -> err_count=8, fail_index=0, pass=0.
- DUT treating j=k=1 as hold:
  - TEST_TOGGLE=1 -> err_count=1, fail_index=5.
  - TEST_TOGGLE=0 -> pass=1, err_count=0.
- rst asserted during vector 3 SETTLE -> next cycle: IDLE, all outputs 0, dut_enable=0. start pulses while busy are ignored (run length unchanged). A new start after rst yields a full 32-cycle run.
- SETTLE_CYCLES=1 and 15 with the correct DUT -> done at cycles 25 and 137 respectively, pass=1. Each dut_enable pulse is exactly 1 cycle wide; 6 pulses are counted.

Source files
------------

// File: rtl/jk_latch_bist_if.sv
// DUT-facing drive/sample bus for the JK latch BIST engine.
// The engine drives j/k/enable into the cell and samples q/q_bar back.
interface jk_latch_bist_if;
   logic dut_j;
   logic dut_k;
   logic dut_enable;
   logic dut_q;
   logic dut_q_bar;

   modport master (
      output dut_j,
      output dut_k,
      output dut_enable,
      input  dut_q,
      input  dut_q_bar
   );

   modport slave (
      input  dut_j,
      input  dut_k,
      input  dut_enable,
      output dut_q,
      output dut_q_bar
   );
endinterface

// File: rtl/jk_latch_bist.sv
// Stimulus-and-check engine for JK latch/flip-flop cells: walks a fixed
// eight-vector table into the cell and scores q/q_bar against expected values.
module jk_latch_bist #(
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter bit          TEST_TOGGLE   = 1'b1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   jk_latch_bist_if.master        dut,
   output logic                   busy,
   output logic                   done,
   output logic                   pass,
   output logic [3:0]             err_count,
   output logic [2:0]             fail_index
);

   localparam int unsigned CNT_W = 4;
   localparam int unsigned IDX_W = 3;
   localparam int unsigned ERR_W = 4;
   localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(7);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, APPLY, SETTLE, CHECK, DONE} state_t;

   typedef struct packed {
      logic j;
      logic k;
      logic en;
   } drive_t;

   // Drive half of the vector table; toggle vectors 5/6 swap out when disabled.
   function automatic drive_t drive_at(input logic [IDX_W-1:0] idx);
      drive_t d;
      case (idx)
         3'd0:    d = '{j: 1'b0, k: 1'b1, en: 1'b1};
         3'd1:    d = '{j: 1'b0, k: 1'b0, en: 1'b1};
         3'd2:    d = '{j: 1'b1, k: 1'b0, en: 1'b1};
         3'd3:    d = '{j: 1'b0, k: 1'b0, en: 1'b0};
         3'd4:    d = '{j: 1'b0, k: 1'b1, en: 1'b0};
         3'd5:    d = TEST_TOGGLE ? '{j: 1'b1, k: 1'b1, en: 1'b1}
                                  : '{j: 1'b1, k: 1'b0, en: 1'b1};
         3'd6:    d = TEST_TOGGLE ? '{j: 1'b1, k: 1'b1, en: 1'b1}
                                  : '{j: 1'b0, k: 1'b0, en: 1'b1};
         default: d = '{j: 1'b0, k: 1'b1, en: 1'b1};
      endcase
      return d;
   endfunction

   // Expected q after each vector has been applied and settled.
   function automatic logic expect_at(input logic [IDX_W-1:0] idx);
      logic q;
      case (idx)
         3'd0:    q = 1'b0;
         3'd1:    q = 1'b0;
         3'd2:    q = 1'b1;
         3'd3:    q = 1'b1;
         3'd4:    q = 1'b1;
         3'd5:    q = TEST_TOGGLE ? 1'b0 : 1'b1;
         3'd6:    q = 1'b1;
         default: q = 1'b0;
      endcase
      return q;
   endfunction

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [ERR_W-1:0]   err_q, err_d;
   logic [IDX_W-1:0]   fi_q, fi_d;
   logic               j_q, j_d, k_q, k_d, en_q, en_d;
   logic               busy_q, busy_d, done_q, done_d, pass_q, pass_d;
   drive_t             nxt_drv;
   logic               mismatch;

   // Vector to launch next: vector 0 from IDLE/DONE, idx+1 from CHECK.
   assign nxt_drv  = drive_at((state_q == CHECK) ? IDX_W'(idx_q + 3'd1) : 3'd0);
   assign mismatch = (dut.dut_q != expect_at(idx_q)) || (dut.dut_q_bar == dut.dut_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         err_q   <= '0;
         fi_q    <= '0;
         j_q     <= 1'b0;
         k_q     <= 1'b0;
         en_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         fi_q    <= fi_d;
         j_q     <= j_d;
         k_q     <= k_d;
         en_q    <= en_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
      end
   end

   // Next-state and next-output logic; drive registers load on the edge entering APPLY.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      fi_d    = fi_q;
      j_d     = j_q;
      k_d     = k_q;
      en_d    = 1'b0;
      busy_d  = busy_q;
      done_d  = done_q;
      pass_d  = pass_q;

      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = APPLY;
               idx_d   = '0;
               cnt_d   = '0;
               err_d   = '0;
               fi_d    = '0;
               done_d  = 1'b0;
               pass_d  = 1'b0;
               busy_d  = 1'b1;
               j_d     = nxt_drv.j;
               k_d     = nxt_drv.k;
               en_d    = nxt_drv.en;
            end
         end
         APPLY: begin
            state_d = SETTLE;
            cnt_d   = '0;
         end
         SETTLE: begin
            if (cnt_q == SETTLE_LAST) begin
               state_d = CHECK;
               cnt_d   = '0;
            end else begin
               cnt_d = CNT_W'(cnt_q + 4'd1);
            end
         end
         CHECK: begin
            if (mismatch) begin
               err_d = ERR_W'(err_q + 4'd1);
               if (err_q == '0) fi_d = idx_q;
            end
            if (idx_q == LAST_IDX) begin
               state_d = DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               pass_d  = (err_d == '0);
               j_d     = 1'b0;
               k_d     = 1'b0;
            end else begin
               state_d = APPLY;
               idx_d   = IDX_W'(idx_q + 3'd1);
               j_d     = nxt_drv.j;
               k_d     = nxt_drv.k;
               en_d    = nxt_drv.en;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign dut.dut_j      = j_q;
   assign dut.dut_k      = k_q;
   assign dut.dut_enable = en_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign pass           = pass_q;
   assign err_count      = err_q;
   assign fail_index     = fi_q;

endmodule

// File: tb/tb_jk_latch_bist.sv
// Bench for jk_latch_bist: four engine instances (settle 2/2/1/15, toggle on/off)
// each paired with a behavioural JK cell whose fault mode is selectable at run time.
module tb_jk_latch_bist;

   localparam int NI    = 4;
   localparam int LIMIT = 400;
   localparam int S_TAB [NI] = '{2, 2, 1, 15};
   localparam bit T_TAB [NI] = '{1'b1, 1'b0, 1'b1, 1'b1};

   // Cell fault modes: 0 correct, 1 q stuck 0 / q_bar 1, 2 q_bar tied to q, 3 toggle treated as hold.
   logic clk = 1'b0;
   logic rst;
   logic [NI-1:0] start, busy_v, done_v, pass_v, dj, dk, den;
   logic [3:0] ec [NI];
   logic [2:0] fi [NI];
   int mode [NI];
   int checks = 0;
   int errors = 0;

   typedef struct {
      int         done_cyc;
      int         pulses;
      bit         busy_ok;
      bit         width_ok;
      bit         jk_ok;
      bit         clear_ok;
      logic [7:0] res;
   } obs_t;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_inst
      jk_latch_bist_if bus ();
      logic st;

      jk_latch_bist #(.SETTLE_CYCLES(S_TAB[g]), .TEST_TOGGLE(T_TAB[g])) u_dut (
         .clk        (clk),
         .rst        (rst),
         .start      (start[g]),
         .dut        (bus),
         .busy       (busy_v[g]),
         .done       (done_v[g]),
         .pass       (pass_v[g]),
         .err_count  (ec[g]),
         .fail_index (fi[g])
      );

      assign dj[g]  = bus.dut_j;
      assign dk[g]  = bus.dut_k;
      assign den[g] = bus.dut_enable;

      always_ff @(posedge clk) begin
         if (bus.dut_enable) begin
            if (bus.dut_j && bus.dut_k) st <= (mode[g] == 3) ? st : ~st;
            else if (bus.dut_j)         st <= 1'b1;
            else if (bus.dut_k)         st <= 1'b0;
         end
      end

      assign bus.dut_q     = (mode[g] == 1) ? 1'b0 : st;
      assign bus.dut_q_bar = (mode[g] == 1) ? 1'b1 : (mode[g] == 2) ? st : ~st;
   end

   // Reference vector table as independent columns.
   function automatic logic [2:0] drive_vec(input int v, input bit tog);
      int tj [8] = '{0, 0, 1, 0, 0, 1, 1, 0};
      int tk [8] = '{1, 0, 0, 0, 1, 1, 1, 1};
      int te [8] = '{1, 1, 1, 0, 0, 1, 1, 1};
      if (!tog) begin
         tj[5] = 1; tk[5] = 0;
         tj[6] = 0; tk[6] = 0;
      end
      return {tj[v] != 0, tk[v] != 0, te[v] != 0};
   endfunction

   function automatic bit exp_q(input int v, input bit tog);
      int tq [8] = '{0, 0, 1, 1, 1, 0, 1, 0};
      if (!tog) begin
         tq[5] = 1; tq[6] = 1;
      end
      return tq[v] != 0;
   endfunction

   // Whole-run outcome: error count and first failing vector for a given cell fault.
   function automatic void model_run(input int m, input bit tog, output int errs, output int first);
      logic [2:0] d;
      bit st, dq, dqb;
      st = 1'b0; errs = 0; first = 0;
      for (int v = 0; v < 8; v++) begin
         d = drive_vec(v, tog);
         if (d[0]) begin
            if (d[2] && d[1]) st = (m == 3) ? st : !st;
            else if (d[2])    st = 1'b1;
            else if (d[1])    st = 1'b0;
         end
         dq  = (m == 1) ? 1'b0 : st;
         dqb = (m == 1) ? 1'b1 : (m == 2) ? dq : !dq;
         if (dq != exp_q(v, tog) || dqb == dq) begin
            if (errs == 0) first = v;
            errs++;
         end
      end
   endfunction

   // Launch a run on instance i (called at a negedge) and record what it did.
   task automatic run_obs(input int i, input int poke, output obs_t o);
      int en_idx [6] = '{0, 1, 2, 5, 6, 7};
      bit prev_en = 1'b0;
      o.done_cyc = -1; o.pulses = 0; o.busy_ok = 1'b1; o.width_ok = 1'b1;
      o.jk_ok = 1'b1; o.clear_ok = 1'b1; o.res = '0;
      start[i] = 1'b1;
      for (int c = 1; c <= LIMIT; c++) begin
         @(negedge clk);
         if (c == 1 && (done_v[i] || pass_v[i] || ec[i] != 4'd0 || fi[i] != 3'd0)) o.clear_ok = 1'b0;
         if (done_v[i]) begin
            o.done_cyc = c;
            o.res = {pass_v[i], ec[i], fi[i]};
            break;
         end
         if (!busy_v[i]) o.busy_ok = 1'b0;
         if (den[i]) begin
            if (prev_en) o.width_ok = 1'b0;
            if (o.pulses < 6 && {dj[i], dk[i], den[i]} !== drive_vec(en_idx[o.pulses], T_TAB[i]))
               o.jk_ok = 1'b0;
            o.pulses++;
         end
         prev_en  = den[i];
         start[i] = (c == poke);
      end
      start[i] = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         checks++;
         if ({busy_v[i], done_v[i], pass_v[i], ec[i], fi[i], dj[i], dk[i], den[i]} !== 14'd0) begin
            errors++;
            $display("FAIL reset_state inst%0d: got %b, want all zero", i,
                     {busy_v[i], done_v[i], pass_v[i], ec[i], fi[i], dj[i], dk[i], den[i]});
         end
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_correct_dut();
      obs_t o;
      int errs, first;
      for (int i = 0; i < NI; i++) begin
         mode[i] = 0;
         run_obs(i, 0, o);
         model_run(0, T_TAB[i], errs, first);
         checks++;
         if (o.done_cyc != 1 + 8 * (S_TAB[i] + 2)) begin
            errors++;
            $display("FAIL correct_done_cycle inst%0d: got %0d, want %0d", i, o.done_cyc, 1 + 8 * (S_TAB[i] + 2));
         end
         checks++;
         if (o.res !== {errs == 0, 4'(errs), 3'(first)}) begin
            errors++;
            $display("FAIL correct_result inst%0d: got pass/err/idx %b, want %b", i, o.res, {errs == 0, 4'(errs), 3'(first)});
         end
         checks++;
         if (o.pulses != 6 || !o.width_ok || !o.jk_ok || !o.busy_ok) begin
            errors++;
            $display("FAIL correct_drive inst%0d: got pulses=%0d width_ok=%0d jk_ok=%0d busy_ok=%0d, want 6/1/1/1",
                     i, o.pulses, o.width_ok, o.jk_ok, o.busy_ok);
         end
      end
      repeat (5) @(negedge clk);
      checks++;
      if ({done_v[0], pass_v[0], busy_v[0], dj[0], dk[0], den[0]} !== 6'b110000) begin
         errors++;
         $display("FAIL done_hold: got %b, want 110000", {done_v[0], pass_v[0], busy_v[0], dj[0], dk[0], den[0]});
      end
   endtask

   task automatic test_faults();
      int inst_l [5] = '{0, 0, 0, 1, 1};
      int mode_l [5] = '{1, 2, 3, 3, 1};
      obs_t o;
      int errs, first, i;
      for (int n = 0; n < 5; n++) begin
         i = inst_l[n];
         mode[i] = mode_l[n];
         run_obs(i, 0, o);
         model_run(mode_l[n], T_TAB[i], errs, first);
         checks++;
         if (o.res !== {errs == 0, 4'(errs), 3'(first)} || o.done_cyc != 1 + 8 * (S_TAB[i] + 2)) begin
            errors++;
            $display("FAIL fault_mode%0d inst%0d: got res=%b done@%0d, want res=%b done@%0d", mode_l[n], i,
                     o.res, o.done_cyc, {errs == 0, 4'(errs), 3'(first)}, 1 + 8 * (S_TAB[i] + 2));
         end
         mode[i] = 0;
      end
   endtask

   task automatic test_start_ignored();
      obs_t o;
      mode[0] = 0;
      run_obs(0, 10, o);
      checks++;
      if (o.done_cyc != 33 || o.res !== 8'b1000_0000 || !o.busy_ok) begin
         errors++;
         $display("FAIL start_while_busy: got done@%0d res=%b busy_ok=%0d, want done@33 res=10000000 busy_ok=1",
                  o.done_cyc, o.res, o.busy_ok);
      end
   endtask

   task automatic test_reset_mid_run();
      obs_t o;
      mode[0] = 0;
      start[0] = 1'b1;
      for (int c = 1; c <= 14; c++) begin
         @(negedge clk);
         start[0] = 1'b0;
      end
      checks++;
      if ({busy_v[0], den[0]} !== 2'b10) begin
         errors++;
         $display("FAIL pre_reset_settle: got busy/en %b, want 10", {busy_v[0], den[0]});
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({busy_v[0], done_v[0], pass_v[0], ec[0], fi[0], dj[0], dk[0], den[0]} !== 14'd0) begin
         errors++;
         $display("FAIL mid_run_reset: got %b, want all zero",
                  {busy_v[0], done_v[0], pass_v[0], ec[0], fi[0], dj[0], dk[0], den[0]});
      end
      repeat (4) @(negedge clk);
      checks++;
      if ({busy_v[0], done_v[0], den[0]} !== 3'b000) begin
         errors++;
         $display("FAIL post_reset_idle: got %b, want 000", {busy_v[0], done_v[0], den[0]});
      end
      run_obs(0, 0, o);
      checks++;
      if (o.done_cyc != 33 || o.res !== 8'b1000_0000) begin
         errors++;
         $display("FAIL rerun_after_reset: got done@%0d res=%b, want done@33 res=10000000", o.done_cyc, o.res);
      end
   endtask

   task automatic test_back_to_back();
      obs_t o1, o2;
      mode[0] = 1;
      run_obs(0, 0, o1);
      checks++;
      if (o1.res !== 8'b0_0100_010) begin
         errors++;
         $display("FAIL b2b_first_run: got %b, want 00100010", o1.res);
      end
      mode[0] = 0;
      run_obs(0, 0, o2);
      checks++;
      if (!o2.clear_ok || o2.done_cyc != 33 || o2.res !== 8'b1000_0000) begin
         errors++;
         $display("FAIL b2b_restart: got clear_ok=%0d done@%0d res=%b, want 1/33/10000000",
                  o2.clear_ok, o2.done_cyc, o2.res);
      end
   endtask

   task automatic test_random();
      obs_t o;
      int i, m, errs, first;
      for (int n = 0; n < 8; n++) begin
         i = int'($urandom_range(0, NI - 1));
         m = int'($urandom_range(0, 3));
         repeat ($urandom_range(0, 5)) @(negedge clk);
         mode[i] = m;
         run_obs(i, int'($urandom_range(0, 30)), o);
         model_run(m, T_TAB[i], errs, first);
         checks++;
         if (o.res !== {errs == 0, 4'(errs), 3'(first)} || o.done_cyc != 1 + 8 * (S_TAB[i] + 2) || !o.width_ok) begin
            errors++;
            $display("FAIL random_run%0d inst%0d mode%0d: got res=%b done@%0d width_ok=%0d, want res=%b done@%0d", n, i, m,
                     o.res, o.done_cyc, o.width_ok, {errs == 0, 4'(errs), 3'(first)}, 1 + 8 * (S_TAB[i] + 2));
         end
         mode[i] = 0;
      end
   endtask

   initial begin
      start = '0;
      rst   = 1'b1;
      for (int i = 0; i < NI; i++) mode[i] = 0;
      test_reset();
      test_correct_dut();
      test_faults();
      test_start_ignored();
      test_reset_mid_run();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
